// File: rtl/mpsk_pkg.sv
// rtl/mpsk_pkg.sv - shared constants and helpers for the M-PSK symbol slicer
package mpsk_pkg;

  localparam int BPSK_BITS = 1;
  localparam int QPSK_BITS = 2;

  // Quadrant index as (sign I, sign Q); a negative sign means the MSB is set
  localparam logic [1:0] QUAD_PP = 2'd0;
  localparam logic [1:0] QUAD_NP = 2'd1;
  localparam logic [1:0] QUAD_NN = 2'd2;
  localparam logic [1:0] QUAD_PN = 2'd3;

  function automatic int acc_width(input int data_width, input int sps);
    return data_width + $clog2(sps);
  endfunction

  function automatic logic [1:0] quad_index(input logic s_i, input logic s_q);
    case ({s_i, s_q})
      2'b00:   return QUAD_PP;
      2'b10:   return QUAD_NP;
      2'b11:   return QUAD_NN;
      default: return QUAD_PN;
    endcase
  endfunction

endpackage

// File: rtl/mpsk_diff_decoder.sv
// rtl/mpsk_diff_decoder.sv - modular phase-index difference against the previous symbol
module mpsk_diff_decoder
  import mpsk_pkg::*;
#(
  parameter int W = QPSK_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe,
  input  logic [W-1:0] k,
  output logic [W-1:0] diff
);

  logic [W-1:0] k_prev;

  // W-bit subtraction wraps, giving the difference mod 2^W directly
  assign diff = k - k_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_prev <= '0;
    end else if (strobe) begin
      k_prev <= k;
    end
  end

endmodule

// File: rtl/mpsk_symbol_slicer.sv
// rtl/mpsk_symbol_slicer.sv - integrate-and-dump with BPSK/QPSK hard decision
module mpsk_symbol_slicer
  import mpsk_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int SPS          = 8,
  parameter int BITS_PER_SYM = 2,
  parameter int DIFF_DEC     = 0,
  parameter int ACC_WIDTH    = acc_width(DATA_WIDTH, SPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  input  logic signed [DATA_WIDTH-1:0] in_q,
  input  logic                        sym_align,
  output logic                        sym_valid,
  output logic [BITS_PER_SYM-1:0]     sym_bits,
  output logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [ACC_WIDTH-1:0] acc_q
);

  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_WIDTH-1:0] run_i, run_q;
  logic signed [ACC_WIDTH-1:0] ext_i, ext_q;
  logic signed [ACC_WIDTH-1:0] sum_i, sum_q;
  logic                        s_i, s_q;
  logic                        dump;
  logic [BITS_PER_SYM-1:0]     abs_bits, k_now, diff_bits;

  assign ext_i = {{(ACC_WIDTH - DATA_WIDTH){in_i[DATA_WIDTH-1]}}, in_i};
  assign ext_q = {{(ACC_WIDTH - DATA_WIDTH){in_q[DATA_WIDTH-1]}}, in_q};
  assign sum_i = run_i + ext_i;
  assign sum_q = run_q + ext_q;

  // Sign bits of the final sums; a zero sum has MSB 0 and so decides positive
  assign s_i = sum_i[ACC_WIDTH-1];
  assign s_q = sum_q[ACC_WIDTH-1];

  // Realign overrides a dump that would otherwise land in the same cycle
  assign dump = in_valid && (cnt == LAST) && !sym_align;

  generate
    if (BITS_PER_SYM == BPSK_BITS) begin : g_bpsk
      assign abs_bits = s_i;
      assign k_now    = s_i;
    end else begin : g_qpsk
      assign abs_bits = {s_i, s_q};
      assign k_now    = quad_index(s_i, s_q);
    end
  endgenerate

  mpsk_diff_decoder #(
    .W(BITS_PER_SYM)
  ) u_diff (
    .clk   (clk),
    .rst   (rst),
    .strobe(dump),
    .k     (k_now),
    .diff  (diff_bits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      run_i     <= '0;
      run_q     <= '0;
      sym_valid <= 1'b0;
      sym_bits  <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
    end else begin
      sym_valid <= 1'b0;
      if (sym_align) begin
        cnt   <= in_valid ? CNT_W'(1) : '0;
        run_i <= in_valid ? ext_i : '0;
        run_q <= in_valid ? ext_q : '0;
      end else if (in_valid) begin
        if (dump) begin
          cnt       <= '0;
          run_i     <= '0;
          run_q     <= '0;
          acc_i     <= sum_i;
          acc_q     <= sum_q;
          sym_bits  <= (DIFF_DEC != 0) ? diff_bits : abs_bits;
          sym_valid <= 1'b1;
        end else begin
          cnt   <= cnt + CNT_W'(1);
          run_i <= sum_i;
          run_q <= sum_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpsk_symbol_slicer.sv
// tb/tb_mpsk_symbol_slicer.sv - directed checks of the M-PSK symbol slicer
module tb_mpsk_symbol_slicer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic signed [15:0] in_i = '0;
  logic signed [15:0] in_q = '0;
  logic        sym_align = 1'b0;

  logic        q_sv, d_sv, b_sv;
  logic [1:0]  q_bits, d_bits;
  logic [0:0]  b_bits;
  logic signed [18:0] q_acc_i, q_acc_q, d_acc_i, d_acc_q;
  logic signed [17:0] b_acc_i, b_acc_q;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mpsk_symbol_slicer #(.DATA_WIDTH(16), .SPS(8), .BITS_PER_SYM(2), .DIFF_DEC(0)) u_qpsk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .sym_align(sym_align), .sym_valid(q_sv), .sym_bits(q_bits),
    .acc_i(q_acc_i), .acc_q(q_acc_q)
  );

  mpsk_symbol_slicer #(.DATA_WIDTH(16), .SPS(8), .BITS_PER_SYM(2), .DIFF_DEC(1)) u_diff (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .sym_align(sym_align), .sym_valid(d_sv), .sym_bits(d_bits),
    .acc_i(d_acc_i), .acc_q(d_acc_q)
  );

  mpsk_symbol_slicer #(.DATA_WIDTH(16), .SPS(4), .BITS_PER_SYM(1), .DIFF_DEC(0)) u_bpsk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .sym_align(sym_align), .sym_valid(b_sv), .sym_bits(b_bits),
    .acc_i(b_acc_i), .acc_q(b_acc_q)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int vi, input int vq, input logic align);
    in_valid  = 1'b1;
    in_i      = 16'(vi);
    in_q      = 16'(vq);
    sym_align = align;
    tick();
    in_valid  = 1'b0;
    sym_align = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Eight equal samples into the differential instance, checking the decision
  task automatic diff_symbol(input int vi, input int vq, input int exp_bits, input string tag);
    for (int n = 0; n < 8; n++) send(vi, vq, 1'b0);
    check({tag, "_sv"}, d_sv, 1);
    check(tag, d_bits, exp_bits);
  endtask

  initial begin
    do_reset();
    check("rst_sv", q_sv, 0);
    check("rst_bits", q_bits, 0);
    check("rst_acc_i", q_acc_i, 0);
    check("rst_acc_q", q_acc_q, 0);

    // Contiguous QPSK symbol
    for (int n = 0; n < 8; n++) begin
      send(1000, -500, 1'b0);
      if (n < 7) check("t1_early", q_sv, 0);
    end
    check("t1_sv", q_sv, 1);
    check("t1_acc_i", q_acc_i, 8000);
    check("t1_acc_q", q_acc_q, -4000);
    check("t1_bits", q_bits, 2'b01);
    tick();
    check("t1_sv_drop", q_sv, 0);
    check("t1_hold", q_acc_i, 8000);

    // Gapped in_valid
    for (int n = 0; n < 8; n++) begin
      send(1000, -500, 1'b0);
      if (n < 7) begin
        check("t2_early", q_sv, 0);
        tick();
        check("t2_idle", q_sv, 0);
      end
    end
    check("t2_sv", q_sv, 1);
    check("t2_acc_i", q_acc_i, 8000);
    check("t2_acc_q", q_acc_q, -4000);
    check("t2_bits", q_bits, 2'b01);
    tick();

    // Realign after a partial symbol
    for (int n = 0; n < 5; n++) send(1000, 1000, 1'b0);
    sym_align = 1'b1;
    tick();
    sym_align = 1'b0;
    check("t3_align_sv", q_sv, 0);
    for (int n = 0; n < 8; n++) begin
      send(-200, -200, 1'b0);
      if (n < 7) check("t3_early", q_sv, 0);
    end
    check("t3_sv", q_sv, 1);
    check("t3_acc_i", q_acc_i, -1600);
    check("t3_acc_q", q_acc_q, -1600);
    check("t3_bits", q_bits, 2'b11);
    tick();

    // Realign coincident with the would-be last sample
    for (int n = 0; n < 7; n++) send(100, 100, 1'b0);
    send(300, -300, 1'b1);
    check("t4_no_dump", q_sv, 0);
    check("t4_held", q_acc_i, -1600);
    for (int n = 0; n < 7; n++) begin
      send(100, 100, 1'b0);
      if (n < 6) check("t4_early", q_sv, 0);
    end
    check("t4_sv", q_sv, 1);
    check("t4_acc_i", q_acc_i, 1000);
    check("t4_acc_q", q_acc_q, 400);
    check("t4_bits", q_bits, 2'b00);
    tick();

    // Differential decode: quadrants 0,1,3,3,0,1
    do_reset();
    diff_symbol( 100,  100, 0, "d_q0");
    diff_symbol(-100,  100, 1, "d_q1");
    diff_symbol( 100, -100, 2, "d_q3a");
    diff_symbol( 100, -100, 0, "d_q3b");
    diff_symbol( 100,  100, 1, "d_q0b");
    diff_symbol(-100,  100, 1, "d_q1b");
    for (int n = 0; n < 3; n++) send(1000, 1000, 1'b0);
    rst = 1'b1;
    tick();
    check("d_rst_bits", d_bits, 0);
    check("d_rst_acc_i", d_acc_i, 0);
    check("d_rst_sv", d_sv, 0);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      send(-100, -100, 1'b0);
      if (n < 7) check("d_post_early", d_sv, 0);
    end
    check("d_post_sv", d_sv, 1);
    check("d_post_bits", d_bits, 2);
    check("d_post_acc_i", d_acc_i, -800);

    // BPSK, SPS=4: sums 0, +4, -4
    do_reset();
    send(1, 1, 1'b0); send(-1, -1, 1'b0); send(1, 1, 1'b0); send(-1, -1, 1'b0);
    check("b0_sv", b_sv, 1);
    check("b0_acc", b_acc_i, 0);
    check("b0_bits", b_bits, 0);
    for (int n = 0; n < 4; n++) send(1, 1, 1'b0);
    check("b4_acc", b_acc_i, 4);
    check("b4_bits", b_bits, 0);
    for (int n = 0; n < 4; n++) send(-1, -1, 1'b0);
    check("bm4_sv", b_sv, 1);
    check("bm4_acc", b_acc_i, -4);
    check("bm4_bits", b_bits, 1);
    tick();
    check("b_sv_drop", b_sv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
